// File: rtl/dynamic_display_scanner_pkg.sv
// Shared types and constants for the dynamic display (DD) 7-segment scan path.
// Ports: none (package). Provides DD_* path/array types, DD_InArrayAt accessor,
//        LED_i_POS byte positions, DEF_COUNT / CountPath, LED_CTRL_* codes, DD_DigitPath.
package BasicTypes;

    localparam int DD_NUMBER      = 2;   // displays driven in lock-step
    localparam int DD_DIGIT_NUM   = 4;   // digits per display
    localparam int DD_SEG_WIDTH   = 8;   // 7 segments + dp
    localparam int DD_IN_WIDTH    = 32;  // source word per display
    localparam int DD_DIGIT_WIDTH = 2;

    typedef logic [DD_SEG_WIDTH-1:0]            DD_Path;
    typedef logic [DD_DIGIT_NUM-1:0]            DD_GatePath;
    typedef logic [DD_IN_WIDTH-1:0]             DD_InPath;
    typedef logic [DD_NUMBER*DD_IN_WIDTH-1:0]   DD_InArray;
    typedef logic [DD_NUMBER*DD_SEG_WIDTH-1:0]  DD_OutArray;
    typedef logic [DD_NUMBER*DD_DIGIT_NUM-1:0]  DD_GateArray;
    typedef logic [DD_DIGIT_WIDTH-1:0]          DD_DigitPath;

    typedef logic [31:0] CyclePath;
    typedef logic [27:0] CountPath;

    localparam CountPath DEF_COUNT = 28'h3000;

    localparam logic LED_CTRL_SORT_RESULT = 1'b0;
    localparam logic LED_CTRL_USER        = 1'b1;

    // Digit 0 is the leftmost digit and takes the most significant byte.
    localparam int LED_0_POS = 24;
    localparam int LED_1_POS = 16;
    localparam int LED_2_POS = 8;
    localparam int LED_3_POS = 0;

    function automatic DD_InPath DD_InArrayAt(input DD_InArray arr, input int d);
        return arr[d*DD_IN_WIDTH +: DD_IN_WIDTH];
    endfunction

    function automatic logic [4:0] led_pos(input DD_DigitPath digit);
        logic [4:0] pos;
        case (digit)
            2'd0:    pos = 5'(LED_0_POS);
            2'd1:    pos = 5'(LED_1_POS);
            2'd2:    pos = 5'(LED_2_POS);
            default: pos = 5'(LED_3_POS);
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/dynamic_display_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment byte (bit7 = dp, always off).
// Ports: hex_i [3:0] nibble in; seg_o [7:0] segment byte out, bit order dp,g,f,e,d,c,b,a.
// Zero latency; no flow control.
module hex_to_seg7
    import BasicTypes::*;
(
    input  logic [3:0] hex_i,
    output DD_Path     seg_o
);

    always_comb begin
        seg_o = 8'hFF;
        case (hex_i)
            4'h0: seg_o = 8'hC0;
            4'h1: seg_o = 8'hF9;
            4'h2: seg_o = 8'hA4;
            4'h3: seg_o = 8'hB0;
            4'h4: seg_o = 8'h99;
            4'h5: seg_o = 8'h92;
            4'h6: seg_o = 8'h82;
            4'h7: seg_o = 8'hF8;
            4'h8: seg_o = 8'h80;
            4'h9: seg_o = 8'h90;
            4'hA: seg_o = 8'h88;
            4'hB: seg_o = 8'h83;
            4'hC: seg_o = 8'hC6;
            4'hD: seg_o = 8'hA1;
            4'hE: seg_o = 8'h86;
            4'hF: seg_o = 8'h8E;
            default: seg_o = 8'hFF;
        endcase
    end

endmodule

// File: rtl/dynamic_display_scanner.sv
// Scan controller for two 4-digit 7-segment displays; source latched once per frame.
// Ports: clk, rst_n, ledCtrl, cycle, sortCount, userData in; ddOut, ddGate, frameTick out.
// Optional DD_GHOST_BLANK_EN: blank the first BLANK_COUNT cycles of every digit slot.
module dynamic_display_scanner
    import BasicTypes::*;
#(
    parameter int unsigned SCAN_COUNT  = DEF_COUNT,
    parameter int unsigned BLANK_COUNT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ledCtrl,
    input  CyclePath    cycle,
    input  CyclePath    sortCount,
    input  DD_InArray   userData,
    output DD_OutArray  ddOut,
    output DD_GateArray ddGate,
    output logic        frameTick
);

    // Configuration sanity checks at elaboration.
    if (SCAN_COUNT < 2) begin : g_bad_scan
        $error("SCAN_COUNT must be >= 2");
    end
    if (BLANK_COUNT >= SCAN_COUNT) begin : g_bad_blank
        $error("BLANK_COUNT must be < SCAN_COUNT");
    end

    CountPath    presc_q,  presc_d;
    DD_DigitPath digit_q,  digit_d;
    DD_InArray   shadow_q, shadow_d;
    logic        mode_q,   mode_d;
    logic        first_q,  first_d;
    DD_OutArray  out_q,    out_d;
    DD_GateArray gate_q,   gate_d;
    logic        tick_q,   tick_d;

    logic wrap;
    logic frame_start;

    logic [3:0] nib      [DD_NUMBER];
    DD_Path     seg      [DD_NUMBER];
    DD_Path     usr_byte [DD_NUMBER];
    DD_InPath   word     [DD_NUMBER];

    assign wrap        = (presc_q == CountPath'(SCAN_COUNT - 1));
    // first_q marks the cycle after reset release so the first slot also loads a frame.
    assign frame_start = first_q | (wrap & (digit_q == DD_DigitPath'(DD_DIGIT_NUM - 1)));

    for (genvar g = 0; g < DD_NUMBER; g++) begin : g_disp
        assign word[g]     = DD_InArrayAt(shadow_q, g);
        // Leftmost digit shows the most significant nibble of the low 16 bits.
        assign nib[g]      = word[g][{~digit_q, 2'b00} +: 4];
        assign usr_byte[g] = word[g][led_pos(digit_q) +: 8];

        hex_to_seg7 u_seg (
            .hex_i (nib[g]),
            .seg_o (seg[g])
        );
    end

    always_comb begin
        presc_d  = presc_q;
        digit_d  = digit_q;
        shadow_d = shadow_q;
        mode_d   = mode_q;
        first_d  = 1'b0;
        tick_d   = frame_start;
        gate_d   = '0;
        out_d    = '1;

        // Prescaler holds at 0 during the load cycle so slot 0 is a full SCAN_COUNT long.
        if (!first_q) begin
            if (wrap) begin
                presc_d = '0;
                digit_d = digit_q + 2'd1;
            end else begin
                presc_d = presc_q + CountPath'(1);
            end
        end

        if (frame_start) begin
            shadow_d = (ledCtrl == LED_CTRL_USER) ? userData : {sortCount, cycle};
            mode_d   = ledCtrl;
        end

        // Shadow is not valid until the first load lands, so stay dark that cycle.
        if (!first_q) begin
            for (int d = 0; d < DD_NUMBER; d++) begin
                gate_d[d*DD_DIGIT_NUM +: DD_DIGIT_NUM] = DD_GatePath'(4'b0001 << digit_q);
                out_d[d*DD_SEG_WIDTH +: DD_SEG_WIDTH]  =
                    (mode_q == LED_CTRL_USER) ? usr_byte[d] : seg[d];
            end
`ifdef DD_GHOST_BLANK_EN
            // Dark lead-in at each slot start hides segment ghosting on digit change.
            if (presc_q < CountPath'(BLANK_COUNT)) begin
                gate_d = '0;
                out_d  = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            digit_q  <= '0;
            shadow_q <= '0;
            mode_q   <= 1'b0;
            first_q  <= 1'b1;
            out_q    <= '1;
            gate_q   <= '0;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            mode_q   <= mode_d;
            first_q  <= first_d;
            out_q    <= out_d;
            gate_q   <= gate_d;
            tick_q   <= tick_d;
        end
    end

    assign ddOut     = out_q;
    assign ddGate    = gate_q;
    assign frameTick = tick_q;

endmodule

// File: tb/tb_dynamic_display_scanner.sv
module tb_dynamic_display_scanner;
    import BasicTypes::*;

`ifdef DD_GHOST_BLANK_EN
    localparam logic [7:0] GATE_AT_2  = 8'h00;
    localparam logic [7:0] GATE_AT_10 = 8'h00;
    localparam int         BLANKS_EXP = 8;
`else
    localparam logic [7:0] GATE_AT_2  = 8'h11;
    localparam logic [7:0] GATE_AT_10 = 8'h22;
    localparam int         BLANKS_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ledCtrl;
    CyclePath    cycle;
    CyclePath    sortCount;
    DD_InArray   userData;
    DD_OutArray  ddOut;
    DD_GateArray ddGate;
    logic        frameTick;

    int n_cmp  = 0;
    int n_fail = 0;
    int ncyc   = 0;
    int blanks = 0;

    dynamic_display_scanner #(.SCAN_COUNT(8), .BLANK_COUNT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ledCtrl   (ledCtrl),
        .cycle     (cycle),
        .sortCount (sortCount),
        .userData  (userData),
        .ddOut     (ddOut),
        .ddGate    (ddGate),
        .frameTick (frameTick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step to negedge number n after reset release, tallying blanked cycles in frame 2.
    task automatic goto(input int n);
        while (ncyc < n) begin
            @(negedge clk);
            ncyc++;
            if (ncyc >= 34 && ncyc <= 65 && ddGate == 8'h00 && ddOut == 16'hFFFF)
                blanks++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ledCtrl   = LED_CTRL_SORT_RESULT;
        cycle     = 32'h0000_1234;
        sortCount = 32'h0000_ABCD;
        userData  = '0;

        repeat (3) @(negedge clk);
        check("rst_gate", 64'(ddGate), 64'h00);
        check("rst_out", 64'(ddOut), 64'hFFFF);
        check("rst_tick", 64'(frameTick), 64'h0);

        rst_n = 1'b1;
        ncyc  = 0;
        goto(1);
        check("first_tick", 64'(frameTick), 64'h1);
        check("first_gate", 64'(ddGate), 64'h00);
        goto(2);
        check("gate_n2", 64'(ddGate), 64'(GATE_AT_2));
        check("tick_n2", 64'(frameTick), 64'h0);
        goto(6);
        check("res_d0_gate", 64'(ddGate), 64'h11);
        check("res_d0_out", 64'(ddOut), 64'h88F9);
        goto(9);
        check("gate_n9", 64'(ddGate), 64'h11);
        goto(10);
        check("gate_n10", 64'(ddGate), 64'(GATE_AT_10));
        goto(14);
        check("res_d1_gate", 64'(ddGate), 64'h22);
        check("res_d1_out", 64'(ddOut), 64'h83A4);
        goto(20);
        check("res_d2_gate", 64'(ddGate), 64'h44);
        check("res_d2_out", 64'(ddOut), 64'hC6B0);

        // Switch source mid-frame; must not show until the next frame.
        ledCtrl  = LED_CTRL_USER;
        userData = {32'h0102_0408, 32'h7F3F_0600};
        cycle    = 32'h0000_0000;
        goto(22);
        check("sw_d2_out", 64'(ddOut), 64'hC6B0);
        goto(30);
        check("res_d3_gate", 64'(ddGate), 64'h88);
        check("res_d3_out", 64'(ddOut), 64'hA199);
        goto(32);
        check("tick_n32", 64'(frameTick), 64'h0);
        goto(33);
        check("tick_n33", 64'(frameTick), 64'h1);
        goto(34);
        check("tick_n34", 64'(frameTick), 64'h0);
        goto(38);
        check("usr_d0_gate", 64'(ddGate), 64'h11);
        check("usr_d0_out", 64'(ddOut), 64'h017F);
        goto(46);
        check("usr_d1_out", 64'(ddOut), 64'h023F);
        goto(54);
        check("usr_d2_out", 64'(ddOut), 64'h0406);
        goto(62);
        check("usr_d3_gate", 64'(ddGate), 64'h88);
        check("usr_d3_out", 64'(ddOut), 64'h0800);
        goto(65);
        check("tick_n65", 64'(frameTick), 64'h1);
        check("blank_cycles", 64'(blanks), 64'(BLANKS_EXP));

        // Reset in the middle of digit 3 of the third frame.
        goto(92);
        check("pre_rst_gate", 64'(ddGate), 64'h88);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gate", 64'(ddGate), 64'h00);
        check("arst_out", 64'(ddOut), 64'hFFFF);
        check("arst_tick", 64'(frameTick), 64'h0);
        userData = {32'hAA00_0000, 32'h5500_0000};
        repeat (2) @(negedge clk);
        check("arst_hold_gate", 64'(ddGate), 64'h00);
        rst_n = 1'b1;
        ncyc  = 0;
        goto(1);
        check("re_tick", 64'(frameTick), 64'h1);
        goto(6);
        check("re_d0_gate", 64'(ddGate), 64'h11);
        check("re_d0_out", 64'(ddOut), 64'hAA55);
        goto(14);
        check("re_d1_gate", 64'(ddGate), 64'h22);
        check("re_d1_out", 64'(ddOut), 64'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
